// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: synchronises and deglitches the pins, then deserialises 11-bit frames into scan codes.
// Optional mid-frame watchdog enabled by defining PS2_RX_TIMEOUT_EN.
module ps2_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] scan_code,
    output logic       scan_code_ready,
    output logic       scan_code_error
);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic       ps2_clk_p0, ps2_clk_p1;
    logic       ps2_dat_p0, ps2_dat_p1;
    logic       fclk, fclk_d;
    logic [7:0] flt_cnt;
    logic       fall;

    state_t     state;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic       par_bit;

    // Stage p0/p1: two-flop synchronisers, idle-high
    always_ff @(posedge clk) begin
        if (reset) begin
            ps2_clk_p0 <= 1'b1;
            ps2_clk_p1 <= 1'b1;
            ps2_dat_p0 <= 1'b1;
            ps2_dat_p1 <= 1'b1;
        end else begin
            ps2_clk_p0 <= ps2_clk;
            ps2_clk_p1 <= ps2_clk_p0;
            ps2_dat_p0 <= ps2_dat;
            ps2_dat_p1 <= ps2_dat_p0;
        end
    end

    // Clock filter: fclk follows the synchronised clock only after FILTER_LEN agreeing samples
    always_ff @(posedge clk) begin
        if (reset) begin
            fclk    <= 1'b1;
            fclk_d  <= 1'b1;
            flt_cnt <= 8'd0;
        end else begin
            fclk_d <= fclk;
            if (ps2_clk_p1 == fclk) begin
                flt_cnt <= 8'd0;
            end else if (flt_cnt == 8'(FILTER_LEN - 1)) begin
                fclk    <= ~fclk;
                flt_cnt <= 8'd0;
            end else begin
                flt_cnt <= flt_cnt + 8'd1;
            end
        end
    end

    assign fall = fclk_d & ~fclk;

`ifdef PS2_RX_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wdog;
`endif

    // Frame FSM: samples data on filtered falling edges and emits one-cycle strobes
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            bit_cnt         <= 3'd0;
            shreg           <= 8'h00;
            par_bit         <= 1'b0;
            scan_code       <= 8'h00;
            scan_code_ready <= 1'b0;
            scan_code_error <= 1'b0;
`ifdef PS2_RX_TIMEOUT_EN
            wdog            <= '0;
`endif
        end else begin
            scan_code_ready <= 1'b0;
            scan_code_error <= 1'b0;
`ifdef PS2_RX_TIMEOUT_EN
            // A fall in the same cycle takes priority over the timeout
            if (fall || state == IDLE) begin
                wdog <= '0;
            end else if (wdog == WD_W'(TIMEOUT_CYCLES - 1)) begin
                wdog            <= '0;
                state           <= IDLE;
                scan_code_error <= 1'b1;
            end else begin
                wdog <= wdog + 1'b1;
            end
`endif
            if (fall) begin
                case (state)
                    IDLE: begin
                        if (!ps2_dat_p1) begin
                            state   <= DATA;
                            bit_cnt <= 3'd0;
                        end
                    end
                    DATA: begin
                        shreg   <= {ps2_dat_p1, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        par_bit <= ps2_dat_p1;
                        state   <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (ps2_dat_p1 && (^{shreg, par_bit})) begin
                            scan_code       <= shreg;
                            scan_code_ready <= 1'b1;
                        end else begin
                            scan_code_error <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_rx.sv
// Self-checking bench for ps2_rx: table of frames plus hand-written glitch, reset and timeout sequences,
// with a scoreboard queue of expected strobes (kind, code, exact cycle).
module tb_ps2_rx;

    localparam int FL  = 8;
    localparam int TMO = 1000;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_clk_pin;
    logic       ps2_dat_pin;
    logic [7:0] scan_code;
    logic       scan_code_ready;
    logic       scan_code_error;

    ps2_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TMO)) dut (
        .clk             (clk),
        .reset           (reset),
        .ps2_clk         (ps2_clk_pin),
        .ps2_dat         (ps2_dat_pin),
        .scan_code       (scan_code),
        .scan_code_ready (scan_code_ready),
        .scan_code_error (scan_code_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        logic       bad_par;
        logic       stop;
    } vec_t;

    typedef struct {
        logic       err;
        logic [7:0] code;
        int         due;
    } exp_t;

    exp_t       exp_q[$];
    int         n_vec    = 0;
    int         n_bad    = 0;
    int         n_pushed = 0;
    int         n_strobe = 0;
    logic [7:0] model_sc = 8'h00;
    logic       prev_strb = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Scoreboard: every strobe pops one expectation
    always @(negedge clk) begin
        if (scan_code_ready || scan_code_error) begin
            exp_t e;
            n_strobe++;
            if (scan_code_ready && scan_code_error) chk("both_strobes", 1, 0);
            if (prev_strb) chk("strobe_width", 2, 1);
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("strobe_kind_err", int'(scan_code_error), int'(e.err));
                chk("scan_code", int'(scan_code), int'(e.code));
                chk("strobe_cycle", cyc, e.due);
            end
        end
        prev_strb = scan_code_ready | scan_code_error;
    end

    task automatic push_exp(input logic err, input logic [7:0] code, input int extra);
        exp_t e;
        e.err  = err;
        e.code = code;
        e.due  = cyc + FL + 3 + extra;
        exp_q.push_back(e);
        n_pushed++;
    endtask

    task automatic send_bit(input logic b, input logic push, input logic err,
                            input logic [7:0] code, input int extra);
        @(negedge clk);
        ps2_dat_pin = b;
        repeat (19) @(negedge clk);
        ps2_clk_pin = 1'b0;
        if (push) push_exp(err, code, extra);
        repeat (40) @(negedge clk);
        ps2_clk_pin = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic stop);
        logic ok;
        logic par;
        par = ~(^d) ^ bad_par;
        ok  = stop && !bad_par;
        if (ok) model_sc = d;
        send_bit(1'b0, 1'b0, 1'b0, 8'h00, 0);
        for (int i = 0; i < 8; i++) send_bit(d[i], 1'b0, 1'b0, 8'h00, 0);
        send_bit(par, 1'b0, 1'b0, 8'h00, 0);
        send_bit(stop, 1'b1, !ok, model_sc, 0);
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{8'h1C, 1'b0, 1'b1};
        vecs[1] = '{8'h1C, 1'b1, 1'b1};
        vecs[2] = '{8'hF0, 1'b0, 1'b1};
        vecs[3] = '{8'h1C, 1'b0, 1'b1};
        vecs[4] = '{8'h00, 1'b0, 1'b1};
        vecs[5] = '{8'hFF, 1'b0, 1'b1};
        vecs[6] = '{8'hA5, 1'b0, 1'b0};
        vecs[7] = '{8'hA5, 1'b0, 1'b1};

        reset       = 1'b1;
        ps2_clk_pin = 1'b1;
        ps2_dat_pin = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_scan_code", int'(scan_code), 0);
        chk("reset_ready", int'(scan_code_ready), 0);
        chk("reset_error", int'(scan_code_error), 0);

        // Parity error straight after reset must leave scan_code at 00
        send_frame(8'h1C, 1'b1, 1'b1);

        // Back-to-back table frames, no idle gap
        for (int i = 0; i < 8; i++) send_frame(vecs[i].data, vecs[i].bad_par, vecs[i].stop);

        // Short clock glitch with data low must not start a frame
        begin
            int s0;
            s0 = n_strobe;
            @(negedge clk);
            ps2_dat_pin = 1'b0;
            repeat (5) @(negedge clk);
            ps2_clk_pin = 1'b0;
            repeat (3) @(negedge clk);
            ps2_clk_pin = 1'b1;
            repeat (30) @(negedge clk);
            ps2_dat_pin = 1'b1;
            repeat (10) @(negedge clk);
            chk("glitch_no_strobe", n_strobe, s0);
        end
        send_frame(8'h29, 1'b0, 1'b1);

        // Reset after start + 4 data bits discards the partial frame silently
        send_bit(1'b0, 1'b0, 1'b0, 8'h00, 0);
        for (int i = 0; i < 4; i++) send_bit(i[0], 1'b0, 1'b0, 8'h00, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset    = 1'b0;
        model_sc = 8'h00;
        @(negedge clk);
        chk("midframe_reset_scan_code", int'(scan_code), 0);
        send_frame(8'h5A, 1'b0, 1'b1);

`ifdef PS2_RX_TIMEOUT_EN
        // Stall after 5 bits: error exactly TMO cycles after the last registered fall
        send_bit(1'b0, 1'b0, 1'b0, 8'h00, 0);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0, 1'b0, 8'h00, 0);
        send_bit(1'b0, 1'b1, 1'b1, model_sc, TMO);
        repeat (TMO + 100) @(negedge clk);
        ps2_dat_pin = 1'b1;
        repeat (10) @(negedge clk);
        send_frame(8'h76, 1'b0, 1'b1);
`endif

        begin
            int budget;
            budget = 2000;
            while (exp_q.size() != 0 && budget > 0) begin
                @(negedge clk);
                budget--;
            end
            chk("scoreboard_drained", exp_q.size(), 0);
        end
        repeat (50) @(negedge clk);
        chk("total_strobes", n_strobe, n_pushed);
        chk("final_scan_code", int'(scan_code), int'(model_sc));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
